// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM transmit multiplexer, its demultiplexer
// counterpart and the bench: channel indices and the select type.
package tdm_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_sel_t;

  localparam ch_sel_t CH_A = 2'd0;
  localparam ch_sel_t CH_B = 2'd1;
  localparam ch_sel_t CH_C = 2'd2;
  localparam ch_sel_t CH_D = 2'd3;

endpackage : tdm_pkg

// File: rtl/tdm_mux_tx_if.sv
// Bus between the four source channels / downstream consumer and the
// transmit multiplexer. master = the side feeding sources and Ready,
// slave = the multiplexer itself.
interface tdm_mux_tx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  import tdm_pkg::*;

  logic [WIDTH-1:0]  A, B, C, D;
  logic [NUM_CH-1:0] Valid;
  logic [NUM_CH-1:0] Accept;
  logic [WIDTH-1:0]  MUX;
  ch_sel_t           Select;
  logic              Enable;
  logic              Ready;
  logic [CNT_W-1:0]  Count;

  modport master (
    output A, B, C, D, Valid, Ready,
    input  Accept, MUX, Select, Enable, Count
  );

  modport slave (
    input  A, B, C, D, Valid, Ready,
    output Accept, MUX, Select, Enable, Count
  );

endinterface : tdm_mux_tx_if

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter. Priority starts just after the
// last granted channel and wraps, so the last winner comes last.
module rr_arbiter4
  import tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_sel_t           last,
  output logic [NUM_CH-1:0] grant_oh,
  output ch_sel_t           grant,
  output logic              any
);

  ch_sel_t idx;

  // Scan from lowest priority to highest so the highest-priority request wins.
  always_comb begin
    any      = |req;
    grant    = last;
    grant_oh = '0;
    idx      = last;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = ch_sel_t'(last + k);
      if (req[idx]) grant = idx;
    end
    if (any) grant_oh[grant] = 1'b1;
  end

endmodule : rr_arbiter4

// File: rtl/tdm_mux_tx.sv
// Time-division transmit multiplexer: one-entry buffer per channel,
// round-robin pick of a full buffer onto the shared MUX/Select/Enable bus,
// Ready backpressure and a wrapping transfer counter. All outputs registered.
module tdm_mux_tx
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         reset,
  tdm_mux_tx_if.slave bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t                        state_q, state_d;
  logic [NUM_CH-1:0]             full_q, full_d;
  logic [NUM_CH-1:0][WIDTH-1:0]  buf_q, buf_d;
  logic [WIDTH-1:0]              mux_q, mux_d;
  ch_sel_t                       sel_q, sel_d;
  ch_sel_t                       last_q, last_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [NUM_CH-1:0][WIDTH-1:0]  din;
  logic [NUM_CH-1:0]             grant_oh;
  ch_sel_t                       grant;
  logic                          any;
  logic                          load;

  assign din = {bus.D, bus.C, bus.B, bus.A};

  // Only buffers full before the edge compete, so a fresh capture waits a cycle.
  rr_arbiter4 u_arb (
    .req      (full_q),
    .last     (last_q),
    .grant_oh (grant_oh),
    .grant    (grant),
    .any      (any)
  );

  // Next-state: output stage loads when empty or being consumed; buffers
  // drain on grant and capture only while empty, so never both at once.
  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    buf_d   = buf_q;
    mux_d   = mux_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    load    = (state_q == IDLE) | bus.Ready;

    if (state_q == PRESENT && bus.Ready) cnt_d = cnt_q + CNT_W'(1);

    if (load) begin
      if (any) begin
        state_d = PRESENT;
        mux_d   = buf_q[grant];
        sel_d   = grant;
        last_d  = grant;
      end else begin
        // Bus reads as zero whenever nothing is presented.
        state_d = IDLE;
        mux_d   = '0;
        sel_d   = CH_A;
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (load && grant_oh[i]) begin
        full_d[i] = 1'b0;
      end else if (!full_q[i] && bus.Valid[i]) begin
        full_d[i] = 1'b1;
        buf_d[i]  = din[i];
      end
    end
  end

  // State register; reset discards in-flight words and gives A first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      full_q  <= '0;
      buf_q   <= '0;
      mux_q   <= '0;
      sel_q   <= CH_A;
      last_q  <= CH_D;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      buf_q   <= buf_d;
      mux_q   <= mux_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Accept = ~full_q;
  assign bus.MUX    = mux_q;
  assign bus.Select = sel_q;
  assign bus.Enable = (state_q == PRESENT);
  assign bus.Count  = cnt_q;

endmodule : tdm_mux_tx

// File: tb/tb_tdm_mux_tx.sv
// Bench for tdm_mux_tx: directed scenarios then random traffic. A reference
// model predicts each presented word into a queue; a monitor checks the bus
// against the queue head and the model's buffer/counter state.
`timescale 1ns/100ps
module tb_tdm_mux_tx;
  import tdm_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tdm_mux_tx_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  tdm_mux_tx #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {int sel; int data;} word_t;
  word_t exp_q[$];

  // Reference model state
  bit m_full[4];
  int m_buf[4];
  bit m_pres = 1'b0;
  int m_last = 3;
  int m_cnt  = 0;

  // Model: each edge, count a consumed word, pick the next full buffer in
  // rotating order after the last winner, then capture into empty buffers.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
      m_pres = 1'b0;
      m_last = 3;
      m_cnt  = 0;
    end else begin
      bit was_full[4];
      int din[4];
      int g;
      int c;
      din[0] = bus.A; din[1] = bus.B; din[2] = bus.C; din[3] = bus.D;
      was_full = m_full;
      if (m_pres && bus.Ready) m_cnt = (m_cnt + 1) % (1 << CW);
      if (!m_pres || bus.Ready) begin
        g = -1;
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (g < 0 && was_full[c]) g = c;
        end
        if (g >= 0) begin
          m_pres    = 1'b1;
          m_full[g] = 1'b0;
          m_last    = g;
          exp_q.push_back('{g, m_buf[g]});
        end else begin
          m_pres = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!was_full[i] && bus.Valid[i]) begin
          m_full[i] = 1'b1;
          m_buf[i]  = din[i];
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int rd_idx = 0;
  bit done   = 1'b0;
  bit final_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: runs mid-cycle and right after an asynchronous reset.
  initial forever begin
    int ae;
    @(negedge clk or posedge reset);
    #1;
    ae = 0;
    for (int i = 0; i < 4; i++) if (!m_full[i]) ae |= (1 << i);
    chk("enable", int'(bus.Enable), int'(m_pres));
    chk("accept", int'(bus.Accept), ae);
    chk("count", int'(bus.Count), m_cnt);
    if (!bus.Enable) chk("mux_idle", int'(bus.MUX), 0);
    if (reset) begin
      rd_idx = exp_q.size();
    end else if (bus.Enable) begin
      if (rd_idx >= exp_q.size()) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: word presented with none expected at %0t", $time);
      end else begin
        chk("select", int'(bus.Select), exp_q[rd_idx].sel);
        chk("mux", int'(bus.MUX), exp_q[rd_idx].data);
        if (bus.Ready) rd_idx++;
      end
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      chk("sb_drained", exp_q.size() - rd_idx, 0);
    end
  end

  task automatic drive(input logic [3:0] v, input int a, input int b,
                       input int c, input int d, input bit rdy);
    bus.Valid = v;
    bus.A     = a[W-1:0];
    bus.B     = b[W-1:0];
    bus.C     = c[W-1:0];
    bus.D     = d[W-1:0];
    bus.Ready = rdy;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    drive(4'b0000, 0, 0, 0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single word on C
    drive(4'b0100, 0, 0, 10, 0, 1'b1); step(1);
    drive(4'b0000, 0, 0, 0, 0, 1'b1);  step(4);

    // All channels at once
    drive(4'b1111, 1, 2, 3, 4, 1'b1);  step(1);
    drive(4'b0000, 0, 0, 0, 0, 1'b1);  step(6);

    // Backpressure after the first word appears
    drive(4'b1111, 1, 2, 3, 4, 1'b1);  step(1);
    drive(4'b0000, 0, 0, 0, 0, 1'b1);  step(1);
    bus.Ready = 1'b0;                  step(3);
    bus.Ready = 1'b1;                  step(6);

    // Fairness between continuously requesting A and D
    for (int n = 0; n < 20; n++) begin
      drive(4'b1001, $urandom_range(0, 15), 0, 0, $urandom_range(0, 15), 1'b1);
      step(1);
    end
    drive(4'b0000, 0, 0, 0, 0, 1'b1);  step(4);

    // Full buffer ignores new data until drained
    drive(4'b0010, 0, 5, 0, 0, 1'b0);  step(1);
    drive(4'b0010, 0, 6, 0, 0, 1'b0);  step(2);
    drive(4'b0000, 0, 0, 0, 0, 1'b0);  step(3);
    bus.Ready = 1'b1;                  step(4);

    // Reset while a word is presented and three buffers are full
    drive(4'b0111, 7, 8, 9, 0, 1'b0);  step(3);
    drive(4'b0000, 0, 0, 0, 0, 1'b0);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    drive(4'b1111, 1, 2, 3, 4, 1'b1);  step(1);
    drive(4'b0000, 0, 0, 0, 0, 1'b1);  step(6);

    // Random traffic (long enough to wrap the counter)
    for (int n = 0; n < 600; n++) begin
      drive(4'($urandom_range(0, 15)), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15), ($urandom_range(0, 3) != 0));
      step(1);
    end

    drive(4'b0000, 0, 0, 0, 0, 1'b1);  step(10);
    done = 1'b1;
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tdm_mux_tx
